// File: rtl/calc_entry_buffer_if.sv
// Keypad entry bus between the key scanner (master) and the entry buffer (slave).
// Optional macro CALC_ENTRY_OVF_EN adds the sticky overflow flag ovf.
interface calc_entry_buffer_if #(
    parameter int DIGITS = 5
);
    localparam int CW = $clog2(DIGITS + 1);

    logic                      key_valid;
    logic [3:0]                key_code;
    logic [4*DIGITS-1:0]       value;
    logic                      neg;
    logic [CW-1:0]             count;
    logic                      full;
    logic [4*(DIGITS+1)-1:0]   disp;
`ifdef CALC_ENTRY_OVF_EN
    logic                      ovf;

    modport master (output key_valid, key_code,
                    input  value, neg, count, full, disp, ovf);
    modport slave  (input  key_valid, key_code,
                    output value, neg, count, full, disp, ovf);
`else
    modport master (output key_valid, key_code,
                    input  value, neg, count, full, disp);
    modport slave  (input  key_valid, key_code,
                    output value, neg, count, full, disp);
`endif
endinterface

// File: rtl/calc_entry_buffer.sv
// Keypad entry buffer: assembles a right-aligned BCD operand of up to DIGITS
// digits from key presses, with clear, backspace and sign toggle, and drives
// the display nibble bus (0x0-0x9 digit, 0xE blank, 0xF minus).
// Optional macro CALC_ENTRY_OVF_EN: sticky ovf flag set when a digit is
// rejected in FULL; while set, the display shows an error pattern.
//
// state | meaning
// EMPTY | no digits entered (count == 0)
// ENTRY | 0 < count < DIGITS
// FULL  | count == DIGITS, further digits rejected
module calc_entry_buffer #(
    parameter  int DIGITS = 5,
    localparam int CW     = $clog2(DIGITS + 1)
) (
    input  logic                 clock,
    input  logic                 reset,
    calc_entry_buffer_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ENTRY = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t                    state_q, state_n;
    logic                      key_q;
    logic                      press;
    logic [4*DIGITS-1:0]       value_q, value_n;
    logic                      neg_q, neg_n;
    logic [CW-1:0]             count_q, count_n;
    logic                      full_q, full_n;
    logic [4*(DIGITS+1)-1:0]   disp_q, disp_n;
    logic [4*(DIGITS+1)-1:0]   value_ext;
`ifdef CALC_ENTRY_OVF_EN
    logic                      ovf_q, ovf_n;
`endif

    assign press = bus.key_valid & ~key_q;

    // Register the key strobe, operand state and display image.
    always_ff @(posedge clock) begin
        if (reset) begin
            key_q   <= 1'b0;
            state_q <= EMPTY;
            value_q <= '0;
            neg_q   <= 1'b0;
            count_q <= '0;
            full_q  <= 1'b0;
            disp_q  <= {{DIGITS{4'hE}}, 4'h0};
`ifdef CALC_ENTRY_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            key_q   <= bus.key_valid;
            state_q <= state_n;
            value_q <= value_n;
            neg_q   <= neg_n;
            count_q <= count_n;
            full_q  <= full_n;
            disp_q  <= disp_n;
`ifdef CALC_ENTRY_OVF_EN
            ovf_q   <= ovf_n;
`endif
        end
    end

    // Decode a press into the next operand state, then derive the display
    // from the next-state values so disp updates on the same edge.
    always_comb begin
        state_n = state_q;
        value_n = value_q;
        neg_n   = neg_q;
        count_n = count_q;
`ifdef CALC_ENTRY_OVF_EN
        ovf_n   = ovf_q;
`endif

        if (press) begin
            if (bus.key_code <= 4'd9) begin
                case (state_q)
                    EMPTY: begin
                        // Leading zeros are suppressed.
                        if (bus.key_code != 4'd0) begin
                            value_n = {{(4*DIGITS-4){1'b0}}, bus.key_code};
                            count_n = CW'(1);
                            state_n = ENTRY;
                        end
                    end
                    ENTRY: begin
                        value_n = {value_q[4*DIGITS-5:0], bus.key_code};
                        count_n = count_q + CW'(1);
                        state_n = (count_n == CW'(DIGITS)) ? FULL : ENTRY;
                    end
                    FULL: begin
`ifdef CALC_ENTRY_OVF_EN
                        ovf_n = 1'b1;
`endif
                    end
                    default: state_n = EMPTY;
                endcase
            end else if (bus.key_code == 4'hA) begin
                value_n = '0;
                neg_n   = 1'b0;
                count_n = '0;
                state_n = EMPTY;
`ifdef CALC_ENTRY_OVF_EN
                ovf_n   = 1'b0;
`endif
            end else if (bus.key_code == 4'hB) begin
                if (state_q != EMPTY) begin
                    value_n = {4'h0, value_q[4*DIGITS-1:4]};
                    count_n = count_q - CW'(1);
                    if (count_n == '0) begin
                        neg_n   = 1'b0;
                        state_n = EMPTY;
                    end else begin
                        state_n = ENTRY;
                    end
                end
            end else if (bus.key_code == 4'hF) begin
                // No negative zero.
                if (state_q != EMPTY) begin
                    neg_n = ~neg_q;
                end
            end
        end

        full_n = (count_n == CW'(DIGITS));

        // Pad with one extra nibble so the sign position can be indexed
        // uniformly; that pad is never selected as a digit.
        value_ext = {4'hE, value_n};
        disp_n    = '0;
        for (int i = 0; i <= DIGITS; i++) begin
            if (i < int'(count_n)) begin
                disp_n[4*i +: 4] = value_ext[4*i +: 4];
            end else if (neg_n && (i == int'(count_n))) begin
                disp_n[4*i +: 4] = 4'hF;
            end else begin
                disp_n[4*i +: 4] = 4'hE;
            end
        end
        if (count_n == '0) begin
            disp_n[3:0] = 4'h0;
        end
`ifdef CALC_ENTRY_OVF_EN
        if (ovf_n) begin
            disp_n      = {(DIGITS+1){4'hE}};
            disp_n[7:4] = 4'hF;
        end
`endif
    end

    assign bus.value = value_q;
    assign bus.neg   = neg_q;
    assign bus.count = count_q;
    assign bus.full  = full_q;
    assign bus.disp  = disp_q;
`ifdef CALC_ENTRY_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_calc_entry_buffer.sv
// Self-checking bench for calc_entry_buffer: directed steps followed by random
// key presses, checked against a digit-list model of the entry buffer.
module tb_calc_entry_buffer;
    localparam int DIGITS = 5;
    localparam int CW     = $clog2(DIGITS + 1);

    logic clock;
    logic reset;
    int   total;
    int   bad;

    // Model state: entered digits, most significant first.
    int   digits[$];
    bit   mneg;
    bit   movf;

    calc_entry_buffer_if #(.DIGITS(DIGITS)) bus();

    calc_entry_buffer #(.DIGITS(DIGITS)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    function automatic bit ovf_enabled();
`ifdef CALC_ENTRY_OVF_EN
        return 1'b1;
`else
        return 1'b0;
`endif
    endfunction

    function automatic void model_reset();
        digits.delete();
        mneg = 1'b0;
        movf = 1'b0;
    endfunction

    function automatic void model_press(input int code);
        if (code <= 9) begin
            if (digits.size() == DIGITS) begin
                if (ovf_enabled()) movf = 1'b1;
            end else if (!(digits.size() == 0 && code == 0)) begin
                digits.push_back(code);
            end
        end else if (code == 10) begin
            model_reset();
        end else if (code == 11) begin
            if (digits.size() > 0) begin
                void'(digits.pop_back());
                if (digits.size() == 0) mneg = 1'b0;
            end
        end else if (code == 15) begin
            if (digits.size() > 0) mneg = ~mneg;
        end
    endfunction

    task automatic check_all(input string tag);
        logic [4*DIGITS-1:0]     ev;
        logic [4*(DIGITS+1)-1:0] ed;
        logic [CW-1:0]           ec;
        int n;
        n  = digits.size();
        ev = '0;
        foreach (digits[k]) ev = (ev << 4) | (4*DIGITS)'(digits[k]);
        ec = CW'(n);
        for (int i = 0; i <= DIGITS; i++) ed[4*i +: 4] = 4'hE;
        for (int k = 0; k < n; k++) ed[4*k +: 4] = 4'(digits[n-1-k]);
        if (n == 0) ed[3:0] = 4'h0;
        if (mneg) ed[4*n +: 4] = 4'hF;
        if (movf) begin
            for (int i = 0; i <= DIGITS; i++) ed[4*i +: 4] = 4'hE;
            ed[7:4] = 4'hF;
        end

        total++;
        assert (bus.value === ev) else begin
            bad++;
            $error("FAIL %s value: got %h want %h", tag, bus.value, ev);
        end
        total++;
        assert (bus.count === ec) else begin
            bad++;
            $error("FAIL %s count: got %0d want %0d", tag, bus.count, ec);
        end
        total++;
        assert (bus.neg === mneg) else begin
            bad++;
            $error("FAIL %s neg: got %b want %b", tag, bus.neg, mneg);
        end
        total++;
        assert (bus.full === (n == DIGITS)) else begin
            bad++;
            $error("FAIL %s full: got %b want %b", tag, bus.full, (n == DIGITS));
        end
        total++;
        assert (bus.disp === ed) else begin
            bad++;
            $error("FAIL %s disp: got %h want %h", tag, bus.disp, ed);
        end
`ifdef CALC_ENTRY_OVF_EN
        total++;
        assert (bus.ovf === movf) else begin
            bad++;
            $error("FAIL %s ovf: got %b want %b", tag, bus.ovf, movf);
        end
`endif
    endtask

    task automatic expect_lit(input string tag, input logic [31:0] got, input logic [31:0] want);
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s: got %h want %h", tag, got, want);
        end
    endtask

    // One press: strobe high for hold cycles, then low for one cycle.
    task automatic press(input int code, input int hold, input string tag);
        @(negedge clock);
        bus.key_valid = 1'b1;
        bus.key_code  = 4'(code);
        @(posedge clock);
        #1;
        model_press(code);
        check_all(tag);
        for (int h = 1; h < hold; h++) begin
            @(negedge clock);
            bus.key_code = 4'($urandom_range(0, 15));
            @(posedge clock);
        end
        @(negedge clock);
        bus.key_valid = 1'b0;
        @(posedge clock);
        #1;
        check_all({tag, "_rel"});
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset = 1'b1;
        bus.key_valid = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int r;
        int code;
        total = 0;
        bad   = 0;
        model_reset();
        reset         = 1'b1;
        bus.key_valid = 1'b0;
        bus.key_code  = 4'h0;
        repeat (3) @(posedge clock);
        #1;
        check_all("reset");
        expect_lit("reset_disp", 32'(bus.disp), 32'hEEEEE0);
        @(negedge clock);
        reset = 1'b0;

        // Leading zeros then 3, 7.
        press(0, 1, "lz0");
        press(0, 1, "lz1");
        press(3, 1, "d3");
        press(7, 1, "d7");
        expect_lit("p37_value", 32'(bus.value), 32'h00037);
        expect_lit("p37_disp", 32'(bus.disp), 32'hEEEE37);

        // Sign toggle and backspace.
        press(15, 1, "sign");
        expect_lit("sign_disp", 32'(bus.disp), 32'hEEEF37);
        press(11, 1, "bs1");
        expect_lit("bs1_disp", 32'(bus.disp), 32'hEEEEF3);
        press(11, 1, "bs2");
        expect_lit("bs2_disp", 32'(bus.disp), 32'hEEEEE0);
        press(15, 1, "sign_empty");
        press(11, 1, "bs_empty");

        // Fill to capacity and overflow.
        press(10, 1, "clr");
        for (int i = 1; i <= 6; i++) press(i, 1, "fill");
        expect_lit("fill_value", 32'(bus.value), 32'h12345);
        if (ovf_enabled()) expect_lit("ovf_disp", 32'(bus.disp), 32'hEEEEFE);
        press(15, 1, "sign_full");
        press(11, 1, "bs_full");
        press(12, 1, "ign_c");
        press(13, 1, "ign_d");
        press(14, 1, "ign_e");
        press(10, 1, "clr2");

        // Held strobe enters exactly one digit.
        press(5, 10, "hold");
        expect_lit("hold_count", 32'(bus.count), 32'd1);

        // Reset coincident with a press, then a clean press of 9.
        @(negedge clock);
        bus.key_valid = 1'b0;
        @(negedge clock);
        reset         = 1'b1;
        bus.key_valid = 1'b1;
        bus.key_code  = 4'h9;
        @(posedge clock);
        #1;
        model_reset();
        check_all("rst_press");
        @(negedge clock);
        reset = 1'b0;
        @(posedge clock);
        #1;
        model_press(9);
        check_all("after_rst");
        @(negedge clock);
        bus.key_valid = 1'b0;

        // Random presses.
        for (int t = 0; t < 300; t++) begin
            r = $urandom_range(0, 99);
            if (r < 62)      code = $urandom_range(0, 9);
            else if (r < 74) code = 11;
            else if (r < 83) code = 15;
            else if (r < 87) code = 10;
            else             code = $urandom_range(12, 14);
            press(code, $urandom_range(1, 3), "rnd");
            if (t == 150) do_reset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
